mem_bus_initiator: RTL and testbench

// Initiator side of the on-chip sel/wen/address/wdata/rdata memory bus. It accepts

---
 rtl/mem_bus_initiator.sv | 124 ++++++++++++
 tb/tb_mem_bus_initiator.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_initiator.sv
// Native valid/ready request to sel/wen/address bus initiator with RAM/IO decode and wait states.
// Optional build macro MISALIGN_TRAP_EN turns misaligned accesses into error completions.
module mem_bus_initiator #(
    parameter int          ADDR_W      = 12,
    parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
    parameter logic [31:0] RAM_SIZE    = 32'h0000_0800,
    parameter logic [31:0] IO_BASE     = 32'h8000_0000,
    parameter logic [31:0] IO_SIZE     = 32'h0000_0100,
    parameter int          WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_valid,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    output logic              ram_sel,
    output logic              io_sel,
    output logic [3:0]        bus_wen,
    output logic [ADDR_W-1:0] bus_address,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [31:0]       io_rdata,
    output logic              bus_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [31:0] RAM_MASK = ~(RAM_SIZE - 32'd1);
    localparam logic [31:0] IO_MASK  = ~(IO_SIZE - 32'd1);
    localparam logic [3:0]  WS_LAST  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state, next_state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-3:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              ram_q, io_q, err_q;
    logic [31:0]       rdata_q;

    logic              ram_hit, io_hit, strb_ok, align_ok, req_err, last_cycle;
    logic [ADDR_W-3:0] ram_off, io_off;

    // RAM wins any overlap so the two selects can never both be high.
    always_comb begin
        ram_hit = (cpu_addr & RAM_MASK) == RAM_BASE;
        io_hit  = !ram_hit && ((cpu_addr & IO_MASK) == IO_BASE);
        ram_off = cpu_addr[ADDR_W-1:2] - RAM_BASE[ADDR_W-1:2];
        io_off  = cpu_addr[ADDR_W-1:2] - IO_BASE[ADDR_W-1:2];
        case (cpu_wstrb)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: strb_ok = 1'b1;
            default:                            strb_ok = 1'b0;
        endcase
        req_err = !(ram_hit || io_hit) || !strb_ok || !align_ok;
    end

`ifdef MISALIGN_TRAP_EN
    assign align_ok = !((cpu_wstrb == 4'b1111 && cpu_addr[1:0] != 2'b00) ||
                        ((cpu_wstrb == 4'b0011 || cpu_wstrb == 4'b1100) && cpu_addr[0]) ||
                        (cpu_wstrb == 4'b0000 && cpu_addr[1:0] != 2'b00));
`else
    logic unused_addr_lsbs;
    assign align_ok         = 1'b1;
    assign unused_addr_lsbs = ^cpu_addr[1:0];
`endif

    assign last_cycle = (state == ACCESS && WAIT_STATES == 0) ||
                        (state == WAIT && wait_cnt == WS_LAST);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cpu_valid) next_state = req_err ? DONE : ACCESS;
            ACCESS:  next_state = (WAIT_STATES == 0) ? DONE : WAIT;
            WAIT:    if (wait_cnt == WS_LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            ram_q    <= 1'b0;
            io_q     <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (cpu_valid) begin
                    addr_q  <= ram_hit ? ram_off : io_off;
                    wdata_q <= cpu_wdata;
                    wstrb_q <= req_err ? 4'b0000 : cpu_wstrb;
                    ram_q   <= ram_hit && !req_err;
                    io_q    <= io_hit && !req_err;
                    err_q   <= req_err;
                end
                ACCESS:  wait_cnt <= '0;
                WAIT:    wait_cnt <= wait_cnt + 4'd1;
                DONE:    rdata_q <= '0;
                default: ;
            endcase
            // Slaves return data combinationally; sample it on the final select cycle.
            if (last_cycle && wstrb_q == 4'b0000)
                rdata_q <= ram_q ? ram_rdata : io_rdata;
        end
    end

    assign ram_sel     = ram_q && (state == ACCESS || state == WAIT);
    assign io_sel      = io_q && (state == ACCESS || state == WAIT);
    assign bus_wen     = (state == ACCESS) ? wstrb_q : 4'b0000;
    assign bus_address = {addr_q, 2'b00};
    assign bus_wdata   = wdata_q;
    assign cpu_ready   = (state == DONE);
    assign bus_err     = (state == DONE) && err_q;
    assign cpu_rdata   = rdata_q;
endmodule

// File: tb/tb_mem_bus_initiator.sv
// Bench for mem_bus_initiator: one instance with no wait states, one with two, each with
// a RAM/IO slave model, checked per transaction against a shadow-memory reference model.
module tb_mem_bus_initiator;
    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [4:0]  lat;
        logic [3:0]  ram_cyc;
        logic [3:0]  io_cyc;
        logic [3:0]  wen;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        clean;
    } txn_t;

    typedef struct packed {
        logic [1:0]  d;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;
    } stim_t;

    logic clk = 1'b0, rst = 1'b1, mem_init = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]        cpu_valid = '0;
    logic [1:0][31:0]  cpu_addr  = '0;
    logic [1:0][31:0]  cpu_wdata = '0;
    logic [1:0][3:0]   cpu_wstrb = '0;
    wire  [1:0]        cpu_ready, ram_sel, io_sel, bus_err;
    wire  [1:0][31:0]  cpu_rdata, bus_wdata, ram_rdata, io_rdata;
    wire  [1:0][3:0]   bus_wen;
    wire  [1:0][11:0]  bus_address;

    int tests = 0, fails = 0;
    logic [31:0] sh_ram [2][512];
    logic [31:0] sh_io  [2][64];

    function automatic logic [31:0] init_word(int g, int r, int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0103) ^ (32'(r) << 20) ^ (32'(g) << 28);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gd
        logic [31:0] ram_mem [512];
        logic [31:0] io_mem  [64];

        mem_bus_initiator #(.WAIT_STATES(2 * g)) dut (
            .clk(clk), .rst(rst),
            .cpu_valid(cpu_valid[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
            .cpu_wstrb(cpu_wstrb[g]), .cpu_ready(cpu_ready[g]), .cpu_rdata(cpu_rdata[g]),
            .ram_sel(ram_sel[g]), .io_sel(io_sel[g]), .bus_wen(bus_wen[g]),
            .bus_address(bus_address[g]), .bus_wdata(bus_wdata[g]),
            .ram_rdata(ram_rdata[g]), .io_rdata(io_rdata[g]), .bus_err(bus_err[g])
        );

        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 512; i++) ram_mem[i] <= init_word(g, 0, i);
                for (int i = 0; i < 64; i++)  io_mem[i]  <= init_word(g, 1, i);
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_sel[g] && bus_wen[g][b])
                        ram_mem[bus_address[g][10:2]][8*b +: 8] <= bus_wdata[g][8*b +: 8];
                    if (io_sel[g] && bus_wen[g][b])
                        io_mem[bus_address[g][7:2]][8*b +: 8] <= bus_wdata[g][8*b +: 8];
                end
            end
        end
        assign ram_rdata[g] = ram_mem[bus_address[g][10:2]];
        assign io_rdata[g]  = io_mem[bus_address[g][7:2]];
    end

    function automatic string fmt(txn_t t);
        return $sformatf("err=%0b rd=%h lat=%0d ram=%0d io=%0d wen=%b adr=%h wd=%h ok=%0b",
                         t.err, t.rdata, t.lat, t.ram_cyc, t.io_cyc, t.wen, t.addr, t.wdata, t.clean);
    endfunction

    // Reference model: transaction-level result from the address map and strobe rules.
    task automatic predict(input int d, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, output txn_t e);
        int          nws = 2 * d;
        bit          legal, ram, io, mis;
        logic [31:0] off;
        legal = ws inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        ram   = (a & ~32'h7FF) == 32'h0;
        io    = (a & ~32'hFF) == 32'h8000_0000;
        mis   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (ws == 4'hF && a[1:0] != 2'b00) || ((ws == 4'h3 || ws == 4'hC) && a[0]) ||
              (ws == 4'h0 && a[1:0] != 2'b00);
`endif
        e = '0;
        e.clean = 1'b1;
        if (!legal || mis || !(ram || io)) begin
            e.err = 1'b1;
            e.lat = 5'd1;
            return;
        end
        off    = ram ? a : a - 32'h8000_0000;
        e.lat  = 5'(2 + nws);
        e.addr = {off[11:2], 2'b00};
        e.wen  = ws;
        if (ram) e.ram_cyc = 4'(1 + nws);
        else     e.io_cyc  = 4'(1 + nws);
        if (ws == 4'b0000) begin
            e.rdata = ram ? sh_ram[d][off[10:2]] : sh_io[d][off[7:2]];
        end else begin
            e.wdata = wd;
            for (int b = 0; b < 4; b++) if (ws[b]) begin
                if (ram) sh_ram[d][off[10:2]][8*b +: 8] = wd[8*b +: 8];
                else     sh_io[d][off[7:2]][8*b +: 8]   = wd[8*b +: 8];
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after completion.
    task automatic do_txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input bit drop, output txn_t o);
        int k = 0;
        bit seen = 1'b0;
        o = '0;
        o.clean = 1'b1;
        cpu_valid[d] = 1'b1; cpu_addr[d] = a; cpu_wdata[d] = wd; cpu_wstrb[d] = ws;
        while (!seen && k < 30) begin
            @(negedge clk);
            k++;
            if (drop) cpu_valid[d] = 1'b0;
            if (ram_sel[d] && io_sel[d]) o.clean = 1'b0;
            if (ram_sel[d]) o.ram_cyc = o.ram_cyc + 4'd1;
            if (io_sel[d])  o.io_cyc  = o.io_cyc + 4'd1;
            if ((ram_sel[d] || io_sel[d]) && (o.ram_cyc + o.io_cyc) == 1) begin
                o.wen  = bus_wen[d];
                o.addr = bus_address[d];
                if (ws != 4'b0000) o.wdata = bus_wdata[d];
            end else if (bus_wen[d] != 4'b0000) o.clean = 1'b0;
            if (cpu_ready[d]) begin
                seen    = 1'b1;
                o.lat   = 5'(k);
                o.err   = bus_err[d];
                o.rdata = cpu_rdata[d];
                if (ram_sel[d] || io_sel[d]) o.clean = 1'b0;
            end else if (cpu_rdata[d] != 32'h0 || bus_err[d]) o.clean = 1'b0;
        end
        if (!seen) o.lat = 5'h1f;
        cpu_valid[d] = 1'b0;
        @(negedge clk);
        if (cpu_ready[d] || bus_err[d] || cpu_rdata[d] != 32'h0 || ram_sel[d] || io_sel[d])
            o.clean = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({cpu_ready, ram_sel, io_sel, bus_err, bus_wen, bus_address, bus_wdata, cpu_rdata} !== 168'd0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b sel=%b/%b err=%b wen=%h adr=%h wd=%h rd=%h, want all 0",
                     cpu_ready, ram_sel, io_sel, bus_err, bus_wen, bus_address, bus_wdata, cpu_rdata);
        end
    endtask

    task automatic test_ram();
        stim_t q[$];
        txn_t  e, o;
        q.push_back('{2'd0, 32'h10, 32'hCAFEBABE, 4'hF});
        q.push_back('{2'd0, 32'h10, 32'h0, 4'h0});
        q.push_back('{2'd1, 32'h10, 32'hCAFEBABE, 4'hF});
        q.push_back('{2'd1, 32'h10, 32'h0, 4'h0});
        q.push_back('{2'd0, 32'h7FC, 32'h1234_5678, 4'hC});
        q.push_back('{2'd0, 32'h7FC, 32'h0, 4'h0});
        foreach (q[i]) begin
            predict(q[i].d, q[i].a, q[i].wd, q[i].ws, e);
            do_txn(q[i].d, q[i].a, q[i].wd, q[i].ws, 1'b0, o);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL ram[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_io();
        stim_t q[$];
        txn_t  e, o;
        for (int d = 0; d < 2; d++) begin
            q.push_back('{2'(d), 32'h8000_0004, 32'h41, 4'h1});
            q.push_back('{2'(d), 32'h8000_0004, 32'h0, 4'h0});
            q.push_back('{2'(d), 32'h8000_00FE, 32'hBEEF_0000, 4'hC});
            q.push_back('{2'(d), 32'h8000_00FC, 32'h0, 4'h0});
        end
        foreach (q[i]) begin
            predict(q[i].d, q[i].a, q[i].wd, q[i].ws, e);
            do_txn(q[i].d, q[i].a, q[i].wd, q[i].ws, 1'b0, o);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL io[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_errors();
        stim_t q[$];
        txn_t  e, o;
        for (int d = 0; d < 2; d++) begin
            q.push_back('{2'(d), 32'h4000_0000, 32'h0, 4'h0});
            q.push_back('{2'(d), 32'h10, 32'hFFFF_FFFF, 4'h5});
            q.push_back('{2'(d), 32'h10, 32'hFFFF_FFFF, 4'h7});
            q.push_back('{2'(d), 32'h800, 32'h0, 4'h0});
            q.push_back('{2'(d), 32'h8000_0100, 32'h1, 4'h1});
            q.push_back('{2'(d), 32'h10, 32'h0, 4'h0});
        end
        foreach (q[i]) begin
            predict(q[i].d, q[i].a, q[i].wd, q[i].ws, e);
            do_txn(q[i].d, q[i].a, q[i].wd, q[i].ws, 1'b0, o);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL error[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_misalign();
        stim_t q[$];
        txn_t  e, o;
        for (int d = 0; d < 2; d++) begin
            q.push_back('{2'(d), 32'h12, 32'h0, 4'h0});
            q.push_back('{2'(d), 32'h23, 32'hA5A5_5A5A, 4'hF});
            q.push_back('{2'(d), 32'h31, 32'h0000_7777, 4'h3});
            q.push_back('{2'(d), 32'h32, 32'h8888_0000, 4'hC});
            q.push_back('{2'(d), 32'h20, 32'h0, 4'h0});
            q.push_back('{2'(d), 32'h30, 32'h0, 4'h0});
        end
        foreach (q[i]) begin
            predict(q[i].d, q[i].a, q[i].wd, q[i].ws, e);
            do_txn(q[i].d, q[i].a, q[i].wd, q[i].ws, 1'b0, o);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL misalign[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    // Requests issued in the idle cycle right after each ready, with valid dropped early.
    task automatic test_back_to_back();
        txn_t e, o;
        for (int i = 0; i < 8; i++) begin
            int          d  = i % 2;
            logic [31:0] a  = {21'h0, 9'(i * 7 + 40), 2'b00};
            logic [31:0] wd = $urandom;
            logic [3:0]  ws = (i % 4 == 0) ? 4'h0 : 4'hF;
            predict(d, a, wd, ws, e);
            do_txn(d, a, wd, ws, 1'b1, o);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL back_to_back[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
            predict(d, a, 32'h0, 4'h0, e);
            do_txn(d, a, 32'h0, 4'h0, 1'b1, o);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL back_to_back_rd[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid();
        txn_t e, o;
        bit   bad = 1'b0;
        cpu_valid[1] = 1'b1; cpu_addr[1] = 32'h10; cpu_wdata[1] = 32'h0; cpu_wstrb[1] = 4'h0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (ram_sel[1] !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_pre: got ram_sel=%b want 1", ram_sel[1]);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({cpu_ready[1], ram_sel[1], io_sel[1], bus_err[1], bus_wen[1], bus_address[1],
             bus_wdata[1], cpu_rdata[1]} !== 84'd0) begin
            fails++;
            $display("FAIL reset_mid_zero: got rdy=%b sel=%b/%b wen=%h adr=%h rd=%h want 0",
                     cpu_ready[1], ram_sel[1], io_sel[1], bus_wen[1], bus_address[1], cpu_rdata[1]);
        end
        cpu_valid[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ready[1] || ram_sel[1]) bad = 1'b1;
        end
        rst = 1'b0;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL reset_mid_quiet: got activity=1 want 0");
        end
        // A write cut off during its select cycle must leave memory untouched.
        cpu_valid[1] = 1'b1; cpu_addr[1] = 32'h24; cpu_wdata[1] = 32'hDEAD_BEEF; cpu_wstrb[1] = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        #1;
        cpu_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        predict(1, 32'h24, 32'h0, 4'h0, e);
        do_txn(1, 32'h24, 32'h0, 4'h0, 1'b0, o);
        tests++;
        if (o !== e) begin
            fails++;
            $display("FAIL reset_abort_write: got %s want %s", fmt(o), fmt(e));
        end
        predict(1, 32'h10, 32'h0, 4'h0, e);
        do_txn(1, 32'h10, 32'h0, 4'h0, 1'b0, o);
        tests++;
        if (o !== e) begin
            fails++;
            $display("FAIL reset_recover_read: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_random();
        txn_t e, o;
        for (int i = 0; i < 120; i++) begin
            int          d = i % 2;
            logic [31:0] a, wd;
            logic [3:0]  ws;
            bit          drop;
            case ($urandom_range(3))
                0, 1:    a = $urandom & 32'h7FF;
                2:       a = 32'h8000_0000 | ($urandom & 32'hFF);
                default: a = ($urandom_range(1) == 0) ? (32'h4000_0000 | ($urandom & 32'hFFF))
                                                      : (32'h800 | ($urandom & 32'h7FF));
            endcase
            case ($urandom_range(9))
                0, 1, 2: ws = 4'h0;
                3:       ws = 4'hF;
                4:       ws = 4'h1 << $urandom_range(3);
                5:       ws = ($urandom_range(1) == 0) ? 4'h3 : 4'hC;
                6:       ws = 4'hF;
                default: ws = 4'($urandom);
            endcase
            wd   = $urandom;
            drop = 1'($urandom);
            predict(d, a, wd, ws, e);
            do_txn(d, a, wd, ws, drop, o);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL random[%0d] a=%h ws=%b: got %s want %s", i, a, ws, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 512; i++) sh_ram[g][i] = init_word(g, 0, i);
            for (int i = 0; i < 64; i++)  sh_io[g][i]  = init_word(g, 1, i);
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst      = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        test_ram();
        test_io();
        test_errors();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
